muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EXECUTE stage, fed directly by the decode/execute pipeline register's operand and control outputs. It accepts one M-extension operation at a time and computes it with radix-2 shift-add multiplication or restoring division. While busy it raises a stall request to the hazard unit, which freezes fetch/decode and the decode/execute register. It presents the result for exactly one cycle, alongside the ALU result path.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; drops any in-flight operation
- start_e  in  1  M-extension instruction valid in EXECUTE (funct7 = 0000001, OP opcode)
- funct3_e  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rd1_e  in  WIDTH  rs1 operand (post-forwarding)
- rd2_e  in  WIDTH  rs2 operand (post-forwarding)
- busy  out  1  stall request to hazard unit (combinational)
- done  out  1  result valid this cycle
- result  out  WIDTH  operation result; valid only while done=1

## Operation
- FSM states: IDLE, RUN, DONE. Reset/flush → IDLE, count=0, result=0, done=0, all datapath registers 0.
- IDLE: if start_e, latch funct3, take absolute values of signed operands (MUL/MULH/DIV/REM: both signed; MULHSU: rs1 only), record result sign, then → RUN with count=0. Special division cases go IDLE→DONE directly:
  - rs2=0: quotient all-ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): quotient = rs1; remainder = 0.
- RUN: one iteration per cycle; count increments; at count = WIDTH−1 → DONE.
  - Multiply: 2·WIDTH-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift.
  - Divide: restoring; shift the {remainder, quotient} pair left, trial-subtract the divisor, set the quotient bit on non-negative.
- DONE: apply sign correction (two's complement of the 2·WIDTH product, the quotient, or the remainder as recorded). Drive result, set done=1, then → IDLE unconditionally. start_e is ignored in DONE.
- Result select: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
- Remainder sign follows the dividend; quotient is negative iff operand signs differ and the divisor is nonzero.
- busy = (IDLE & start_e & !flush) | RUN. busy is low in DONE, so the pipeline advances on the DONE cycle and writes the result.
- flush wins over every state transition. rst mid-operation returns to IDLE with no done pulse.

## Timing
- Normal op: cycle 0 (IDLE, start_e) busy=1; cycles 1..WIDTH RUN, busy=1; cycle WIDTH+1 DONE, busy=0, done=1.
  - Stall is WIDTH+1 cycles: 33 for WIDTH=32.
- Special-case divide: cycle 0 busy=1; cycle 1 DONE, done=1.
- done is a single-cycle pulse. result holds its value until the next DONE, but consumers sample it only with done.
- Back-to-back M ops: a new start_e is seen no earlier than the cycle after DONE.

## Configuration
- MULDIV_DIV_EN defined: the divider datapath and all DIV/DIVU/REM/REMU behaviour are as above.
- MULDIV_DIV_EN undefined: divider logic is removed. Divide funct3 codes go IDLE→DONE in one cycle with result=0, and multiply is unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - funct3 localparams (F3_MUL … F3_REMU);
  - the M-extension funct7 constant 7'b0000001.
- Sub-module muldiv_divider contains the restoring-division step register pair and trial subtractor. It is instantiated only under MULDIV_DIV_EN.
- The multiplier accumulator, FSM, counter and sign fix-up live in the top module.

## Test plan
- MUL 7 × −3 → busy high 33 cycles, then done=1, result=0xFFFFFFEB. Same operands with MULH → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → result=0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). DIVU 100 / 7 → 14. REMU → 2.
- DIVU 5 / 0 → done on cycle 1, result=0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000, done on cycle 1.
- MUL started, flush asserted at cycle 10 → busy=0 next cycle, no done pulse. A following DIVU 9/3 then completes normally with 3.
- rst asserted asynchronously mid-RUN (cycle 15) → busy, done, result=0 immediately. With MULDIV_DIV_EN undefined, DIV 9/3 → done on cycle 1, result=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Carries the FSM state enum, funct3/funct7 codes and operand-sign helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f3);
    return !(f3 == F3_MULHU || f3 == F3_DIVU ||
             f3 == F3_REMU);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return rs1_signed(f3) && (f3 != F3_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between the D/E register and the muldiv unit.
// master = pipeline side, slave = muldiv unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             start_e;
  logic [2:0]       funct3_e;
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output flush, start_e, funct3_e, rd1_e, rd2_e,
    input  busy, done, result
  );

  modport slave (
    input  flush, start_e, funct3_e, rd1_e, rd2_e,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_divider.sv
// Restoring divider: {rem, quo} step register pair and trial subtractor.
// Works on magnitudes; sign fix-up is done by the caller.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    unique case (1'b1)
      clear: begin
        quo_d = '0;
        rem_d = '0;
        dvs_d = '0;
      end
      load: begin
        quo_d = dividend;
        rem_d = '0;
        dvs_d = divisor;
      end
      step: begin
        // borrow out of the trial subtract means restore
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EXECUTE stage.
// Define MULDIV_DIV_EN to build the divider; otherwise divides return 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave io
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic               spec_q, spec_d;
  logic [WIDTH-1:0]   spec_val_q, spec_val_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               accept;
  logic               a_sgn, b_sgn;
  logic               special;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   special_val;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_val;

  assign accept = (state_q == IDLE) && io.start_e &&
                  !io.flush;

  always_comb begin : decode
    a_sgn = io.rd1_e[WIDTH-1] && rs1_signed(io.funct3_e);
    b_sgn = io.rd2_e[WIDTH-1] && rs2_signed(io.funct3_e);
    a_abs = a_sgn ? -io.rd1_e : io.rd1_e;
    b_abs = b_sgn ? -io.rd2_e : io.rd2_e;
    special     = 1'b0;
    special_val = '0;
`ifdef MULDIV_DIV_EN
    if (is_div(io.funct3_e)) begin
      if (io.rd2_e == '0) begin
        special     = 1'b1;
        special_val = io.funct3_e[1] ? io.rd1_e : '1;
      end else if (rs1_signed(io.funct3_e) &&
                   io.rd1_e == MIN_NEG &&
                   io.rd2_e == '1) begin
        special     = 1'b1;
        special_val = io.funct3_e[1] ? '0 : io.rd1_e;
      end
    end
`else
    special = is_div(io.funct3_e);
`endif
  end

`ifdef MULDIV_DIV_EN
  muldiv_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .clear   (io.flush),
    .load    (accept && is_div(io.funct3_e) && !special),
    .step    (state_q == RUN && is_div(f3_q) && !io.flush),
    .dividend(a_abs),
    .divisor (b_abs),
    .quo     (quo),
    .rem     (rem)
  );
`else
  assign quo = '0;
  assign rem = '0;
`endif

  always_comb begin : datapath
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -acc_q : acc_q;
    if (spec_q) begin
      fix_val = spec_val_q;
    end else if (!f3_q[2]) begin
      fix_val = (f3_q == F3_MUL) ? prod[WIDTH-1:0]
                                 : prod[2*WIDTH-1:WIDTH];
    end else if (!f3_q[1]) begin
      fix_val = neg_q ? -quo : quo;
    end else begin
      fix_val = neg_q ? -rem : rem;
    end
  end

  always_comb begin : fsm
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    result_d   = result_q;
    unique case (state_q)
      IDLE: begin
        if (io.start_e) begin
          f3_d  = io.funct3_e;
          cnt_d = '0;
          // remainder takes the dividend's sign
          neg_d = (io.funct3_e[2] && io.funct3_e[1])
                ? a_sgn : (a_sgn ^ b_sgn);
          spec_d     = special;
          spec_val_d = special_val;
          if (special || is_div(io.funct3_e)) begin
            acc_d   = '0;
            mcand_d = '0;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            mcand_d = a_abs;
          end
          state_d = special ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!f3_q[2]) acc_d = acc_step;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        result_d = fix_val;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (io.flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      f3_d       = '0;
      neg_d      = 1'b0;
      spec_d     = 1'b0;
      spec_val_d = '0;
      acc_d      = '0;
      mcand_d    = '0;
      result_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      result_q   <= result_d;
    end
  end

  assign io.busy   = accept || (state_q == RUN);
  assign io.done   = (state_q == DONE);
  assign io.result = io.done ? fix_val : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic RV32M model.
// Follows MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_if #(.WIDTH(32)) io ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(
    input logic [2:0] f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 0;
    up = 0;
`ifndef MULDIV_DIV_EN
    if (f3[2]) return 32'd0;
`endif
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub;
        return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub;
        return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (!f3[2]) return 33;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  task automatic check(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input string tag,
    input logic [2:0] f3,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int lat;
    int bcnt;
    logic [31:0] res;
    logic bz;
    lat  = -1;
    bcnt = 0;
    res  = 'x;
    bz   = 1'b1;
    @(posedge clk); #1;
    io.start_e  = 1'b1;
    io.funct3_e = f3;
    io.rd1_e    = a;
    io.rd2_e    = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (io.done) begin
        lat = k;
        res = io.result;
        bz  = io.busy;
        break;
      end
      if (io.busy) bcnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    io.start_e = 1'b0;
    check({tag, "/result"}, res, ref_op(f3, a, b));
    check({tag, "/latency"}, lat, ref_lat(f3, a, b));
    check({tag, "/stall"}, bcnt, ref_lat(f3, a, b));
    check({tag, "/busy_in_done"}, {31'd0, bz}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    bit saw;
    io.flush    = 1'b0;
    io.start_e  = 1'b0;
    io.funct3_e = 3'd0;
    io.rd1_e    = 32'd0;
    io.rd2_e    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", {31'd0, io.busy}, 32'd0);
    check("rst/done", {31'd0, io.done}, 32'd0);
    check("rst/result", io.result, 32'd0);
    rst = 1'b0;

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh_7_m3", 3'd1, 32'd7, 32'hFFFF_FFFD);
    run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_5_0", 3'd5, 32'd5, 32'd0);
    run_op("rem_5_0", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // flush a multiply part-way through
    @(posedge clk); #1;
    io.start_e  = 1'b1;
    io.funct3_e = 3'd0;
    io.rd1_e    = 32'd1234;
    io.rd2_e    = 32'd5678;
    repeat (10) @(posedge clk);
    #1 io.flush = 1'b1;
    @(posedge clk); #1;
    io.flush   = 1'b0;
    io.start_e = 1'b0;
    @(negedge clk);
    check("flush/busy", {31'd0, io.busy}, 32'd0);
    check("flush/done", {31'd0, io.done}, 32'd0);
    check("flush/result", io.result, 32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (io.done) saw = 1'b1;
    end
    check("flush/no_done", {31'd0, saw}, 32'd0);
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b);
    end

    // asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    io.start_e  = 1'b1;
    io.funct3_e = 3'd3;
    io.rd1_e    = 32'hDEAD_BEEF;
    io.rd2_e    = 32'h1234_5678;
    repeat (15) @(posedge clk);
    #3;
    rst        = 1'b1;
    io.start_e = 1'b0;
    #1;
    check("arst/busy", {31'd0, io.busy}, 32'd0);
    check("arst/done", {31'd0, io.done}, 32'd0);
    check("arst/result", io.result, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_op("post_rst_mul", 3'd0, 32'hFFFF_FFF0, 32'd16);
    run_op("post_rst_div9", 3'd4, 32'd9, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
